// File: rtl/async_fifo_reader.sv
// async_fifo_reader: read-domain consumer for the team async FIFO.
// Pops words from a first-word-fall-through FIFO port into a 2-entry
// registered buffer and presents them as a valid/ready stream. Each word
// carries an m_last tag every BURST_LEN words.
// Optional build macro ASYNC_FIFO_READER_STATS_EN adds the rd_words and
// rd_stalls handshake/stall counters.
module async_fifo_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             rd_clk,
    input  logic             arreset,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rden,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             burst_busy
`ifdef ASYNC_FIFO_READER_STATS_EN
    ,
    output logic [31:0]      rd_words,
    output logic [31:0]      rd_stalls
`endif
);

    localparam logic [CNT_W-1:0] LP_BEAT_MAX = CNT_W'(BURST_LEN - 1);

    // Buffer occupancy (0, 1 or 2); head entry drives the outputs directly
    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head_data;
    logic             r_head_last;
    logic [WIDTH-1:0] r_tail_data;
    logic             r_tail_last;
    logic [CNT_W-1:0] r_beat;

    logic [1:0]       w_count_next;
    logic [WIDTH-1:0] w_head_data_next;
    logic             w_head_last_next;
    logic [WIDTH-1:0] w_tail_data_next;
    logic             w_tail_last_next;
    logic [CNT_W-1:0] w_beat_next;

    logic             w_push;
    logic             w_pop;
    logic             w_push_last;

    // Output decode: pop strobe depends only on registered occupancy, never on
    // m_ready; it is also held low during reset so no FIFO word is consumed
    // and silently discarded while the buffer is being cleared.
    always_comb begin
        fifo_rden  = en & ~fifo_empty & (r_count != 2'd2) & ~arreset;
        m_valid    = (r_count != 2'd0);
        m_data     = r_head_data;
        m_last     = r_head_last;
        burst_busy = (r_beat != '0);
    end

    assign w_push      = fifo_rden;
    assign w_pop       = m_valid & m_ready;
    assign w_push_last = (r_beat == LP_BEAT_MAX);

    // Next-state: occupancy transitions, entry updates and beat counting
    always_comb begin
        w_count_next     = r_count;
        w_head_data_next = r_head_data;
        w_head_last_next = r_head_last;
        w_tail_data_next = r_tail_data;
        w_tail_last_next = r_tail_last;
        w_beat_next      = r_beat;

        case (r_count)
            2'd0: begin
                if (w_push) begin
                    w_head_data_next = fifo_data;
                    w_head_last_next = w_push_last;
                    w_count_next     = 2'd1;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    // head retires and the new word takes its place
                    w_head_data_next = fifo_data;
                    w_head_last_next = w_push_last;
                end else if (w_push) begin
                    w_tail_data_next = fifo_data;
                    w_tail_last_next = w_push_last;
                    w_count_next     = 2'd2;
                end else if (w_pop) begin
                    w_count_next     = 2'd0;
                end
            end
            2'd2: begin
                if (w_pop) begin
                    w_head_data_next = r_tail_data;
                    w_head_last_next = r_tail_last;
                    w_count_next     = 2'd1;
                end
            end
            default: begin
                w_count_next = 2'd0;
            end
        endcase

        if (w_push) begin
            w_beat_next = w_push_last ? '0 : r_beat + 1'b1;
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge rd_clk or posedge arreset) begin
        if (arreset) begin
            r_count     <= 2'd0;
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
            r_beat      <= '0;
        end else begin
            r_count     <= w_count_next;
            r_head_data <= w_head_data_next;
            r_head_last <= w_head_last_next;
            r_tail_data <= w_tail_data_next;
            r_tail_last <= w_tail_last_next;
            r_beat      <= w_beat_next;
        end
    end

`ifdef ASYNC_FIFO_READER_STATS_EN
    logic [31:0] r_rd_words;
    logic [31:0] r_rd_stalls;

    // Saturating counters of accepted words and back-pressured cycles
    always_ff @(posedge rd_clk or posedge arreset) begin
        if (arreset) begin
            r_rd_words  <= 32'd0;
            r_rd_stalls <= 32'd0;
        end else begin
            if (w_pop && (r_rd_words != 32'hFFFF_FFFF)) begin
                r_rd_words <= r_rd_words + 32'd1;
            end
            if (m_valid && !m_ready && (r_rd_stalls != 32'hFFFF_FFFF)) begin
                r_rd_stalls <= r_rd_stalls + 32'd1;
            end
        end
    end

    assign rd_words  = r_rd_words;
    assign rd_stalls = r_rd_stalls;
`endif

endmodule

// File: tb/tb_async_fifo_reader.sv
// Testbench for async_fifo_reader (BURST_LEN=4). A queue models the FIFO;
// words the DUT pops are pushed into a scoreboard tagged with the expected
// m_last, and a monitor compares every presented output word.
module tb_async_fifo_reader;

    localparam int WIDTH = 8;
    localparam int BL    = 4;

    logic             rd_clk;
    logic             arreset;
    logic             en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rden;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             burst_busy;
`ifdef ASYNC_FIFO_READER_STATS_EN
    logic [31:0]      rd_words;
    logic [31:0]      rd_stalls;
`endif

    async_fifo_reader #(.WIDTH(WIDTH), .BURST_LEN(BL), .CNT_W(16)) dut (
        .rd_clk     (rd_clk),
        .arreset    (arreset),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rden  (fifo_rden),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .burst_busy (burst_busy)
`ifdef ASYNC_FIFO_READER_STATS_EN
        ,
        .rd_words   (rd_words),
        .rd_stalls  (rd_stalls)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] fifo_q[$];   // contents of the modelled FIFO
    logic [WIDTH:0]   sb[$];       // expected {last, data} in delivery order
    int               n_push   = 0; // words popped from the FIFO since reset
    int               pops_cnt = 0; // total pops, used by directed tests
    int               words_m  = 0;
    int               stalls_m = 0;
    bit               rden_s   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    // FIFO model + scoreboard monitor; samples on the falling edge
    initial begin
        fifo_empty = 1'b1;
        fifo_data  = '0;
        forever begin
            @(negedge rd_clk);
            if (arreset) begin
                sb.delete();
                n_push   = 0;
                words_m  = 0;
                stalls_m = 0;
                rden_s   = 0;
            end else begin
                check("m_valid", m_valid, sb.size() != 0);
                check("fifo_rden", fifo_rden, en && !fifo_empty && sb.size() < 2);
                check("burst_busy", burst_busy, (n_push % BL) != 0);
`ifdef ASYNC_FIFO_READER_STATS_EN
                check("rd_words", rd_words, words_m);
                check("rd_stalls", rd_stalls, stalls_m);
`endif
                if (m_valid) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        check("m_data", m_data, sb[0][WIDTH-1:0]);
                        check("m_last", m_last, sb[0][WIDTH]);
                        if (m_ready) begin
                            $display("word %02h last %0d at %0t", m_data, m_last, $time);
                            void'(sb.pop_front());
                            words_m++;
                        end else begin
                            stalls_m++;
                        end
                    end
                end
                rden_s = fifo_rden;
            end
            @(posedge rd_clk);
            if (rden_s) begin
                if (fifo_q.size() == 0) begin
                    check("pop_of_empty_fifo", 1, 0);
                end else begin
                    logic [WIDTH-1:0] w;
                    logic             l;
                    w = fifo_q.pop_front();
                    l = ((n_push + 1) % BL) == 0;
                    sb.push_back({l, w});
                    n_push++;
                    pops_cnt++;
                end
            end
            #2;
            fifo_empty = (fifo_q.size() == 0);
            fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge rd_clk);
        #1;
    endtask

    task automatic load_seq(input int cnt, input logic [WIDTH-1:0] start);
        for (int i = 0; i < cnt; i++) fifo_q.push_back(start + WIDTH'(i));
    endtask

    task automatic load_rand(input int cnt);
        for (int i = 0; i < cnt; i++) fifo_q.push_back(WIDTH'($urandom));
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick(1);
            if (fifo_q.size() == 0 && sb.size() == 0 && !m_valid) done = 1;
        end
        check(name, done, 1);
    endtask

    task automatic reset_pulse();
        @(posedge rd_clk);
        #2 arreset = 1'b1;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_fifo_rden", fifo_rden, 0);
        check("rst_burst_busy", burst_busy, 0);
        @(posedge rd_clk);
        #1 arreset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        arreset = 1'b1;
        en      = 1'b0;
        m_ready = 1'b0;
        #1;
        check("reset_m_valid", m_valid, 0);
        check("reset_fifo_rden", fifo_rden, 0);
        check("reset_m_data", m_data, 0);
        check("reset_m_last", m_last, 0);
        check("reset_burst_busy", burst_busy, 0);
        @(posedge rd_clk);
        #1 arreset = 1'b0;

        // back-to-back stream of 0x01..0x05
        en = 1'b1; m_ready = 1'b1;
        load_seq(5, 8'h01);
        drain("t1_drain");
        check("t1_busy_after_5", burst_busy, 1);

        // back-pressure: only two pops may happen while m_ready is low
        m_ready = 1'b0;
        base = pops_cnt;
        load_seq(6, 8'h01);
        tick(8);
        check("t2_two_pops", pops_cnt - base, 2);
        check("t2_head_held", m_data, 8'h01);
        m_ready = 1'b1;
        drain("t2_drain");

        // m_ready toggling with a continuous 20-word stream
        load_rand(20);
        for (int i = 0; i < 60; i++) begin
            m_ready = i[0];
            tick(1);
        end
        m_ready = 1'b1;
        drain("t3_drain");

        // en dropped mid-burst after 2 of 4 words
        reset_pulse();
        m_ready = 1'b1;
        base = pops_cnt;
        load_seq(4, 8'h40);
        for (int i = 0; i < 20 && (pops_cnt - base) < 2; i++) tick(1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t4_busy_gap", burst_busy, 1);
        end
        en = 1'b1;
        drain("t4_drain");

        // reset while buffer is full and beat count is 3
        reset_pulse();
        load_seq(1, 8'h60);
        drain("t5_pre");
        m_ready = 1'b0;
        load_seq(4, 8'h70);
        tick(6);
        check("t5_full", sb.size(), 2);
        check("t5_beat3", n_push % BL, 3);
        reset_pulse();
        load_seq(4, 8'h80);
        m_ready = 1'b1;
        drain("t5_drain");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(3) != 0);
            m_ready = ($urandom_range(1) != 0);
            if ($urandom_range(2) == 0) load_rand(1 + $urandom_range(3));
            tick(1);
        end
        en = 1'b1; m_ready = 1'b1;
        drain("rand_drain");

`ifdef ASYNC_FIFO_READER_STATS_EN
        // 8 accepted words, exactly 3 stalled cycles
        reset_pulse();
        m_ready = 1'b0;
        load_seq(8, 8'h90);
        for (int i = 0; i < 20 && !m_valid; i++) @(negedge rd_clk);
        repeat (2) @(negedge rd_clk);
        @(posedge rd_clk);
        #1 m_ready = 1'b1;
        drain("stats_drain");
        check("stats_words", rd_words, 8);
        check("stats_stalls", rd_stalls, 3);
        reset_pulse();
        check("stats_words_clr", rd_words, 0);
        check("stats_stalls_clr", rd_stalls, 0);
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
